sdi_frame_rx: RTL and testbench
===============================

Name: sdi_frame_rx

Overview:
- Serial frame receiver; the receive end of the strobed serial data link whose transmitter shifts one bit per `pfbi` strobe onto `psdo` and appends a computed parity bit.
- Deserialises start bit, DATA_W data bits (LSB first) and one parity bit, checks parity, and times out stalled frames.
- Presents each good word on a valid/ready output register with sticky error flags.
- Sits between the link pins and the consuming controller logic.

Parameters:
- DATA_W, 8, data bits per frame (2..16).
- PAR_ODD, 0, 0 = even parity (data plus parity bit has an even count of ones), 1 = odd parity.
- TIMEOUT, 255, maximum clock cycles allowed between strobes inside a frame (1..65535).

Ports:
- pclk  in  1  clock, rising edge.
- prst_n  in  1  synchronous active-low reset.
- piclr  in  1  synchronous clear: aborts any frame and clears flags/counter.
- pfbi  in  1  bit strobe; `psdi` is sampled on edges where `pfbi`=1.
- psdi  in  1  serial data in.
- pdata  out  DATA_W  received word.
- pvalid  out  1  `pdata` holds an unconsumed word.
- pready  in  1  consumer accepts `pdata` when `pvalid` & `pready`.
- pperr  out  1  sticky parity error.
- pterr  out  1  sticky inter-strobe timeout.
- povr  out  1  sticky overrun: a good word was dropped.
- perrcnt  out  8  saturating count of bad frames (parity, timeout, framing).
- pbusy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (`prst_n`=0 at an edge): state IDLE; `pdata`=0, `pvalid`=0, `pperr`=`pterr`=`povr`=0, `perrcnt`=0, bit counter=0, timer=0. Reset mid-frame discards the partial frame.
- `piclr`=1 (with `prst_n`=1): same as reset, except `pdata` is unchanged and `pvalid` is unchanged. `piclr` overrides every other event on that edge.
- States:
  - IDLE: strobe with `psdi`=0 -> DATA, bit counter=0, parity accumulator=PAR_ODD. Strobe with `psdi`=1 is ignored.
  - DATA: each strobe shifts `psdi` into the shift register at bit position = counter, XORs it into the parity accumulator, and increments the counter. The strobe taking the counter to DATA_W -> PAR.
  - PAR: strobe -> compare (accumulator XOR `psdi`). Result 0 = good, 1 = parity error. Then -> IDLE, or -> STOP when SDI_STOP_CHECK_EN is defined.
- Timer: cleared on every strobe and on entry to DATA; increments each non-strobe cycle in DATA/PAR/STOP. When the timer reaches TIMEOUT with no strobe on that edge: `pterr`=1, `perrcnt`+1, -> IDLE, partial frame discarded. A strobe arriving on the same edge wins and no timeout occurs.
- Good frame completion edge:
  - `pvalid`=0: `pdata` loads and `pvalid`=1 at that edge. Latency is zero cycles after the final strobe edge.
  - `pvalid`=1 and `pready`=1: old word is consumed, new word loaded, `pvalid` stays 1, no overrun.
  - `pvalid`=1 and `pready`=0: new word dropped, `povr`=1, `pdata` unchanged.
- Bad frame: word discarded; `pperr`=1; `perrcnt`+1; `pvalid`/`pdata` untouched.
- Handshake: `pvalid` falls on the edge where `pvalid`&`pready`=1 with no simultaneous load. `pdata` is stable while `pvalid`=1.
- `perrcnt` saturates at 255 and does not wrap. Two error events can never occur on one edge.
- Frame start is re-armed immediately: a start strobe on the edge after completion is accepted.

Optional Feature:
- SDI_STOP_CHECK_EN defined: the frame carries an additional stop bit after the parity bit.
  - PAR -> STOP, holding the parity result.
  - On the STOP strobe, `psdi` must be 1; otherwise it is a framing error: `pperr`=1, `perrcnt`+1, word discarded.
  - Word delivery and the parity-error update happen on the STOP strobe, not the PAR strobe.
  - Timer is active in STOP.
- Not defined: STOP state absent; delivery on the PAR strobe.

Test Plan:
- Basic good frame. Defaults; strobes with 0 (start), 1,0,1,0,0,1,0,1 (0xA5 LSB first), parity 0 -> `pdata`=0xA5, `pvalid`=1 on the parity edge; `pready`=1 for one cycle -> `pvalid`=0. No flags set.
- Parity error. Same frame with parity bit 1 -> `pvalid` stays 0, `pperr`=1, `perrcnt`=1. Then `piclr` pulse -> `pperr`=0, `perrcnt`=0.
- Overrun. Deliver 0x3C with `pready`=0, then a good frame 0x11 -> `pdata`=0x3C, `povr`=1. Repeat with `pready`=1 on the completion edge -> `pdata`=0x11, `pvalid`=1, `povr` unchanged.
- Timeout. Start and 3 data strobes, then TIMEOUT idle cycles (TIMEOUT=4 bench) -> `pterr`=1, `pbusy`=0 on the 4th idle edge. A strobe instead on that edge -> no timeout.
- Reset and clear mid-frame. Assert `prst_n`=0 after 5 data bits -> all outputs 0; the following full frame 0x5A is received correctly. Repeat using `piclr` while `pvalid`=1 -> `pvalid` stays 1.
- Stop check (macro defined). Stop bit 0 -> `pperr`=1, word dropped. Stop bit 1 -> delivered on the stop edge.

Source files
------------

// File: rtl/sdi_frame_rx.sv
// sdi_frame_rx: strobed serial frame receiver with parity/timeout checks.
// Optional stop-bit framing check enabled by defining SDI_STOP_CHECK_EN.
module sdi_frame_rx #(
    parameter int DATA_W  = 8,
    parameter bit PAR_ODD = 1'b0,
    parameter int TIMEOUT = 255
) (
    input  logic              pclk,
    input  logic              prst_n,
    input  logic              piclr,
    input  logic              pfbi,
    input  logic              psdi,
    output logic [DATA_W-1:0] pdata,
    output logic              pvalid,
    input  logic              pready,
    output logic              pperr,
    output logic              pterr,
    output logic              povr,
    output logic [7:0]        perrcnt,
    output logic              pbusy
);

    localparam int CW = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_PAR  = 2'd2
`ifdef SDI_STOP_CHECK_EN
        ,
        S_STOP = 2'd3
`endif
    } state_t;

    state_t            state, state_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic [DATA_W-1:0] shreg, sh_n;
    logic              acc, acc_n;
    logic [15:0]       tmr, tmr_n;
    logic [16:0]       tmr_inc;
    logic              tmo, done, good;
    logic [DATA_W-1:0] data_n;
    logic              valid_n, perr_n, terr_n, ovr_n;
    logic [7:0]        ecnt_n;
`ifdef SDI_STOP_CHECK_EN
    logic              pbad, pbad_n;
`endif

    assign tmr_inc = {1'b0, tmr} + 17'd1;
    assign pbusy   = (state != S_IDLE);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        sh_n    = shreg;
        acc_n   = acc;
        tmr_n   = tmr;
        tmo     = 1'b0;
        done    = 1'b0;
        good    = 1'b0;
`ifdef SDI_STOP_CHECK_EN
        pbad_n  = pbad;
`endif
        if (state != S_IDLE) begin
            if (pfbi)
                tmr_n = 16'd0;
            else if (tmr_inc >= 17'(TIMEOUT))
                tmo = 1'b1;
            else
                tmr_n = tmr_inc[15:0];
        end
        unique case (state)
            S_IDLE: begin
                if (pfbi && !psdi) begin
                    state_n = S_DATA;
                    cnt_n   = '0;
                    sh_n    = '0;
                    acc_n   = PAR_ODD;
                    tmr_n   = 16'd0;
                end
            end
            S_DATA: begin
                if (pfbi) begin
                    sh_n  = shreg | (DATA_W'(psdi) << cnt);
                    acc_n = acc ^ psdi;
                    cnt_n = cnt + CW'(1);
                    if (cnt == CW'(DATA_W - 1))
                        state_n = S_PAR;
                end
            end
            S_PAR: begin
                if (pfbi) begin
`ifdef SDI_STOP_CHECK_EN
                    pbad_n  = acc ^ psdi;
                    state_n = S_STOP;
`else
                    done    = 1'b1;
                    good    = ~(acc ^ psdi);
                    state_n = S_IDLE;
                    cnt_n   = '0;
`endif
                end
            end
`ifdef SDI_STOP_CHECK_EN
            S_STOP: begin
                if (pfbi) begin
                    // a low stop bit is a framing error
                    done    = 1'b1;
                    good    = ~pbad & psdi;
                    state_n = S_IDLE;
                    cnt_n   = '0;
                end
            end
`endif
            default: state_n = S_IDLE;
        endcase
        if (tmo) begin
            state_n = S_IDLE;
            cnt_n   = '0;
            tmr_n   = 16'd0;
        end
    end

    always_comb begin
        data_n  = pdata;
        valid_n = pvalid;
        perr_n  = pperr;
        terr_n  = pterr;
        ovr_n   = povr;
        ecnt_n  = perrcnt;
        if (pvalid && pready)
            valid_n = 1'b0;
        if (done && good) begin
            if (!pvalid || pready) begin
                data_n  = shreg;
                valid_n = 1'b1;
            end else begin
                ovr_n = 1'b1;
            end
        end
        if (done && !good)
            perr_n = 1'b1;
        if (tmo)
            terr_n = 1'b1;
        if (((done && !good) || tmo) && perrcnt != 8'hFF)
            ecnt_n = perrcnt + 8'd1;
    end

    always_ff @(posedge pclk) begin
        if (!prst_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            shreg   <= '0;
            acc     <= 1'b0;
            tmr     <= 16'd0;
            pdata   <= '0;
            pvalid  <= 1'b0;
            pperr   <= 1'b0;
            pterr   <= 1'b0;
            povr    <= 1'b0;
            perrcnt <= 8'd0;
`ifdef SDI_STOP_CHECK_EN
            pbad    <= 1'b0;
`endif
        end else if (piclr) begin
            state   <= S_IDLE;
            cnt     <= '0;
            tmr     <= 16'd0;
            pperr   <= 1'b0;
            pterr   <= 1'b0;
            povr    <= 1'b0;
            perrcnt <= 8'd0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            shreg   <= sh_n;
            acc     <= acc_n;
            tmr     <= tmr_n;
            pdata   <= data_n;
            pvalid  <= valid_n;
            pperr   <= perr_n;
            pterr   <= terr_n;
            povr    <= ovr_n;
            perrcnt <= ecnt_n;
`ifdef SDI_STOP_CHECK_EN
            pbad    <= pbad_n;
`endif
        end
    end

endmodule

// File: tb/tb_sdi_frame_rx.sv
// Testbench for sdi_frame_rx: directed plan cases plus randomized frames,
// scored against a word-queue reference model.
module tb_sdi_frame_rx;

    localparam int  DW = 8;
    localparam bit  PO = 1'b0;
    localparam int  TO = 4;

    logic          pclk = 1'b0;
    logic          prst_n = 1'b0;
    logic          piclr = 1'b0;
    logic          pfbi = 1'b0;
    logic          psdi = 1'b0;
    logic [DW-1:0] pdata;
    logic          pvalid;
    logic          pready = 1'b0;
    logic          pperr, pterr, povr, pbusy;
    logic [7:0]    perrcnt;

    sdi_frame_rx #(.DATA_W(DW), .PAR_ODD(PO), .TIMEOUT(TO)) dut (
        .pclk(pclk), .prst_n(prst_n), .piclr(piclr), .pfbi(pfbi),
        .psdi(psdi), .pdata(pdata), .pvalid(pvalid), .pready(pready),
        .pperr(pperr), .pterr(pterr), .povr(povr), .perrcnt(perrcnt),
        .pbusy(pbusy)
    );

    always #5 pclk = ~pclk;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] exp_q[$];
    bit            m_valid = 0;
    logic [DW-1:0] m_data = '0;
    bit            m_perr = 0, m_terr = 0, m_ovr = 0;
    int            m_ecnt = 0;
    int            gap_max = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // consumer side: a word leaves on each edge where pvalid & pready
    always @(negedge pclk) begin
        if (prst_n && !piclr && pvalid && pready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_word", {24'd0, pdata}, 32'hFFFF_FFFF);
            end else begin
                chk("consumed_word", {24'd0, pdata}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    function automatic void err_evt();
        if (m_ecnt < 255) m_ecnt++;
    endfunction

    // rmode: 0 ready low, 1 ready high, 2 random
    task automatic cyc(input bit fb, input bit sd, input bit dg,
                       input logic [DW-1:0] w, input int rmode);
        pfbi = fb;
        psdi = sd;
        case (rmode)
            0: pready = 1'b0;
            1: pready = 1'b1;
            default: pready = 1'($urandom_range(0, 1));
        endcase
        if (dg) begin
            if (!m_valid || pready) begin
                exp_q.push_back(w);
                m_valid = 1;
                m_data  = w;
            end else begin
                m_ovr = 1;
            end
        end else if (m_valid && pready) begin
            m_valid = 0;
        end
        @(posedge pclk);
        #1;
        pfbi = 1'b0;
        pready = 1'b0;
    endtask

    task automatic gaps(input int rmode);
        int n;
        n = $urandom_range(0, gap_max);
        repeat (n) cyc(1'b0, 1'($urandom_range(0, 1)), 1'b0, '0, rmode);
    endtask

    task automatic send_bits(input logic [DW-1:0] w, input int from,
                             input bit bad, input bit stop_ok,
                             input int rmode, input int fin);
        bit par, ok;
        for (int i = from; i < DW; i++) begin
            gaps(rmode);
            cyc(1'b1, w[i], 1'b0, '0, rmode);
        end
        par = (^w) ^ PO ^ bad;
        gaps(rmode);
`ifdef SDI_STOP_CHECK_EN
        cyc(1'b1, par, 1'b0, '0, rmode);
        gaps(rmode);
        ok = !bad && stop_ok;
        cyc(1'b1, stop_ok, ok, w, fin);
`else
        ok = !bad;
        cyc(1'b1, par, ok, w, fin);
`endif
        if (!ok) begin
            m_perr = 1;
            err_evt();
        end
    endtask

    task automatic send_frame(input logic [DW-1:0] w, input bit bad,
                              input bit stop_ok, input int rmode,
                              input int fin);
        cyc(1'b1, 1'b0, 1'b0, '0, rmode);
        send_bits(w, 0, bad, stop_ok, rmode, fin);
    endtask

    task automatic timeout_frame(input int k, input int rmode);
        cyc(1'b1, 1'b0, 1'b0, '0, rmode);
        for (int i = 0; i < k; i++)
            cyc(1'b1, 1'($urandom_range(0, 1)), 1'b0, '0, rmode);
        repeat (TO) cyc(1'b0, 1'b0, 1'b0, '0, rmode);
        m_terr = 1;
        err_evt();
    endtask

    task automatic do_reset();
        prst_n = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, '0, 0);
        prst_n = 1'b1;
        if (m_valid) void'(exp_q.pop_back());
        m_valid = 0;
        m_data  = '0;
        m_perr = 0; m_terr = 0; m_ovr = 0; m_ecnt = 0;
    endtask

    task automatic do_clr();
        piclr = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, '0, 0);
        piclr = 1'b0;
        m_perr = 0; m_terr = 0; m_ovr = 0; m_ecnt = 0;
    endtask

    task automatic chk_state(input string tag);
        chk({tag, "_pvalid"}, {31'd0, pvalid}, {31'd0, m_valid});
        chk({tag, "_pdata"}, {24'd0, pdata}, {24'd0, m_data});
        chk({tag, "_pperr"}, {31'd0, pperr}, {31'd0, m_perr});
        chk({tag, "_pterr"}, {31'd0, pterr}, {31'd0, m_terr});
        chk({tag, "_povr"}, {31'd0, povr}, {31'd0, m_ovr});
        chk({tag, "_perrcnt"}, {24'd0, perrcnt}, 32'(m_ecnt));
        chk({tag, "_pbusy"}, {31'd0, pbusy}, 32'd0);
    endtask

    task automatic drain();
        repeat (3) cyc(1'b0, 1'b0, 1'b0, '0, 1);
        chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("drain_pvalid", {31'd0, pvalid}, 32'd0);
    endtask

    initial begin
        logic [DW-1:0] w;
        int kind;

        prst_n = 1'b0;
        repeat (2) @(posedge pclk);
        #1;
        prst_n = 1'b1;
        chk_state("reset");
        chk("reset_pdata_zero", {24'd0, pdata}, 32'h0);

        // basic good frame 0xA5
        gap_max = 0;
        send_frame(8'hA5, 1'b0, 1'b1, 0, 0);
        chk("basic_pvalid", {31'd0, pvalid}, 32'd1);
        chk("basic_pdata", {24'd0, pdata}, 32'hA5);
        chk_state("basic");
        cyc(1'b0, 1'b0, 1'b0, '0, 1);
        chk("basic_consumed", {31'd0, pvalid}, 32'd0);

        // parity error then clear
        send_frame(8'hA5, 1'b1, 1'b1, 0, 0);
        chk("perr_flag", {31'd0, pperr}, 32'd1);
        chk("perr_cnt", {24'd0, perrcnt}, 32'd1);
        chk_state("perr");
        do_clr();
        chk("clr_perr", {31'd0, pperr}, 32'd0);
        chk("clr_cnt", {24'd0, perrcnt}, 32'd0);

        // overrun, then completion with ready high
        send_frame(8'h3C, 1'b0, 1'b1, 0, 0);
        send_frame(8'h11, 1'b0, 1'b1, 0, 0);
        chk("ovr_pdata", {24'd0, pdata}, 32'h3C);
        chk("ovr_flag", {31'd0, povr}, 32'd1);
        send_frame(8'h11, 1'b0, 1'b1, 0, 1);
        chk("ovr2_pdata", {24'd0, pdata}, 32'h11);
        chk("ovr2_pvalid", {31'd0, pvalid}, 32'd1);
        chk_state("ovr");
        drain();
        do_clr();

        // timeout on exactly the TO-th idle edge
        w = 8'h96;
        cyc(1'b1, 1'b0, 1'b0, '0, 0);
        for (int i = 0; i < 3; i++) cyc(1'b1, w[i], 1'b0, '0, 0);
        repeat (TO - 1) cyc(1'b0, 1'b0, 1'b0, '0, 0);
        chk("to_busy_before", {31'd0, pbusy}, 32'd1);
        chk("to_terr_before", {31'd0, pterr}, 32'd0);
        cyc(1'b0, 1'b0, 1'b0, '0, 0);
        m_terr = 1;
        err_evt();
        chk("to_terr", {31'd0, pterr}, 32'd1);
        chk("to_busy_after", {31'd0, pbusy}, 32'd0);
        chk_state("to");
        do_clr();

        // strobe on the would-be timeout edge wins
        cyc(1'b1, 1'b0, 1'b0, '0, 0);
        for (int i = 0; i < 3; i++) cyc(1'b1, w[i], 1'b0, '0, 0);
        repeat (TO - 1) cyc(1'b0, 1'b0, 1'b0, '0, 0);
        cyc(1'b1, w[3], 1'b0, '0, 0);
        chk("noto_terr", {31'd0, pterr}, 32'd0);
        chk("noto_busy", {31'd0, pbusy}, 32'd1);
        send_bits(w, 4, 1'b0, 1'b1, 0, 0);
        chk("noto_pdata", {24'd0, pdata}, 32'h96);
        chk_state("noto");

        // reset mid-frame
        cyc(1'b1, 1'b0, 1'b0, '0, 0);
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b0, '0, 0);
        do_reset();
        chk_state("midrst");
        send_frame(8'h5A, 1'b0, 1'b1, 0, 0);
        chk("midrst_5a", {24'd0, pdata}, 32'h5A);
        // clear mid-frame while a word is held
        cyc(1'b1, 1'b0, 1'b0, '0, 0);
        for (int i = 0; i < 2; i++) cyc(1'b1, 1'b1, 1'b0, '0, 0);
        do_clr();
        chk("midclr_pvalid", {31'd0, pvalid}, 32'd1);
        chk_state("midclr");
        drain();

`ifdef SDI_STOP_CHECK_EN
        send_frame(8'h77, 1'b0, 1'b0, 0, 0);
        chk("stop_bad_perr", {31'd0, pperr}, 32'd1);
        chk("stop_bad_pvalid", {31'd0, pvalid}, 32'd0);
        send_frame(8'h77, 1'b0, 1'b1, 0, 0);
        chk("stop_good_pdata", {24'd0, pdata}, 32'h77);
        chk_state("stop");
        drain();
        do_clr();
`endif

        // error counter saturates at 255
        repeat (260) timeout_frame(0, 0);
        chk("sat_cnt", {24'd0, perrcnt}, 32'd255);
        chk_state("sat");
        do_clr();

        // randomized frames
        gap_max = TO - 1;
        repeat (80) begin
            w = DW'($urandom);
            kind = $urandom_range(0, 9);
            if ($urandom_range(0, 3) == 0)
                cyc(1'b1, 1'b1, 1'b0, '0, 2);
            if (kind == 0)
                timeout_frame($urandom_range(0, DW), 2);
            else if (kind == 1)
                send_frame(w, 1'b1, 1'b1, 2, 2);
            else if (kind == 2)
                send_frame(w, 1'b0, 1'($urandom_range(0, 1)), 2, 2);
            else
                send_frame(w, 1'b0, 1'b1, 2, 2);
            chk_state("rand");
            if ($urandom_range(0, 15) == 0) do_clr();
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
